// File: rtl/con_reply_route.sv
// con_reply_route: fixed-latency pass-through plus masked, length-limited packet replay.
module con_reply_route #(
  parameter int DW        = 8,
  parameter int DLY       = 13,
  parameter int NCH       = 4,
  parameter int MAXLEN    = 256,
  parameter int STRIP_HDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] con_din,
  input  logic          con_din_en,
  output logic [DW-1:0] con_dout,
  output logic          con_dout_en,
  output logic [DW-1:0] replay_dout,
  output logic [NCH-1:0] replay_dout_en,
  output logic [15:0]   pkt_cnt,
  output logic          err_long
);
  logic [DW:0]    dly_q [DLY];
  logic           prev_en_q;
  logic [NCH-1:0] mask_q, mask_d, cur_mask;
  logic [15:0]    cnt_q, cnt_d, pkt_q, pkt_d;
  logic           errd_q, errd_d;
  logic [DW-1:0]  s1_dat_q, s1_dat_d, s2_dat_q;
  logic [NCH-1:0] s1_en_q, s1_en_d, s2_en_q;
  logic           s1_err_q, s1_err_d, s2_err_q;
  logic           start, pkt_end, elig, room;
  assign start    = con_din_en & ~prev_en_q;
  assign pkt_end  = ~con_din_en & prev_en_q;
  // The header byte itself already uses the mask it carries.
  assign cur_mask = start ? con_din[NCH-1:0] : mask_q;
  assign elig     = con_din_en && (|cur_mask) && !(start && STRIP_HDR != 0);
  assign room     = cnt_q < 16'(MAXLEN);
  always_comb begin
    mask_d   = pkt_end ? '0 : cur_mask;
    cnt_d    = pkt_end ? '0 : cnt_q + 16'(elig && room);
    errd_d   = pkt_end ? 1'b0 : errd_q | (elig & ~room);
    s1_en_d  = (elig && room) ? cur_mask : '0;
    s1_dat_d = (elig && room) ? con_din : '0;
    s1_err_d = elig & ~room & ~errd_q;
    pkt_d    = pkt_q + 16'(pkt_end && cnt_q != 16'd0);
  end
  // prev_en resets high so a packet already running at release is ignored.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      prev_en_q <= 1'b1;
      mask_q    <= '0;
      cnt_q     <= '0;
      errd_q    <= 1'b0;
      pkt_q     <= '0;
      s1_dat_q  <= '0;
      s1_en_q   <= '0;
      s1_err_q  <= 1'b0;
      s2_dat_q  <= '0;
      s2_en_q   <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      dly_q[0] <= {con_din_en, con_din};
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      prev_en_q <= con_din_en;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      errd_q    <= errd_d;
      pkt_q     <= pkt_d;
      s1_dat_q  <= s1_dat_d;
      s1_en_q   <= s1_en_d;
      s1_err_q  <= s1_err_d;
      s2_dat_q  <= s1_dat_q;
      s2_en_q   <= s1_en_q;
      s2_err_q  <= s1_err_q;
    end
  assign {con_dout_en, con_dout} = dly_q[DLY-1];
  assign replay_dout    = s2_dat_q;
  assign replay_dout_en = s2_en_q;
  assign pkt_cnt        = pkt_q;
  assign err_long       = s2_err_q;
endmodule

// File: tb/tb_con_reply_route.sv
// tb_con_reply_route: three configurations driven by one stimulus, checked against a packet-level model.
module tb_con_reply_route;
  typedef struct packed {logic [7:0] d; logic [3:0] en; logic err;} rec_t;
  localparam int DLYS [3]  = '{13, 13, 2};
  localparam int MAXL [3]  = '{256, 256, 3};
  localparam int STRIP [3] = '{0, 1, 0};
  logic clk = 0, rst = 0;
  logic [7:0] con_din = 0;
  logic con_din_en = 0;
  logic [7:0] o_d [3];
  logic o_en [3];
  logic [7:0] r_d [3];
  logic [3:0] r_en [3];
  logic [15:0] pc [3];
  logic e_l [3];
  int total = 0, bad = 0, cyc_n = 0;
  logic [8:0] hq[$];
  bit ign [3], errd [3];
  int pos [3], nrep [3], pkt [3];
  logic [3:0] mask [3];
  rec_t p1 [3], p2 [3];
  logic [11:0] log0[$], log1[$], log2[$];
  int errcnt2 = 0, err_cyc = 0, last_rep2 = 0;

  always #5 clk = ~clk;

  con_reply_route u0 (.clk(clk), .rst(rst), .con_din(con_din), .con_din_en(con_din_en),
    .con_dout(o_d[0]), .con_dout_en(o_en[0]), .replay_dout(r_d[0]), .replay_dout_en(r_en[0]),
    .pkt_cnt(pc[0]), .err_long(e_l[0]));
  con_reply_route #(.STRIP_HDR(1)) u1 (.clk(clk), .rst(rst), .con_din(con_din), .con_din_en(con_din_en),
    .con_dout(o_d[1]), .con_dout_en(o_en[1]), .replay_dout(r_d[1]), .replay_dout_en(r_en[1]),
    .pkt_cnt(pc[1]), .err_long(e_l[1]));
  con_reply_route #(.MAXLEN(3), .DLY(2)) u2 (.clk(clk), .rst(rst), .con_din(con_din), .con_din_en(con_din_en),
    .con_dout(o_d[2]), .con_dout_en(o_en[2]), .replay_dout(r_d[2]), .replay_dout_en(r_en[2]),
    .pkt_cnt(pc[2]), .err_long(e_l[2]));

  task automatic model_reset();
    hq.delete();
    for (int c = 0; c < 3; c++) begin
      ign[c] = 1; errd[c] = 0; pos[c] = -1; nrep[c] = 0; pkt[c] = 0; mask[c] = 0;
      p1[c] = '0; p2[c] = '0;
    end
  endtask

  task automatic model_step(input logic e, input logic [7:0] d);
    hq.push_front({e, d});
    if (hq.size() > 64) void'(hq.pop_back());
    for (int c = 0; c < 3; c++) begin
      rec_t r = '0;
      if (ign[c]) begin
        if (!e) ign[c] = 0;
      end else if (e) begin
        if (pos[c] < 0) begin pos[c] = 0; mask[c] = d[3:0]; nrep[c] = 0; errd[c] = 0; end
        else pos[c]++;
        if (mask[c] != 0 && !(STRIP[c] != 0 && pos[c] == 0)) begin
          if (nrep[c] < MAXL[c]) begin r.d = d; r.en = mask[c]; nrep[c]++; end
          else if (!errd[c]) begin r.err = 1; errd[c] = 1; end
        end
      end else if (pos[c] >= 0) begin
        if (nrep[c] > 0) pkt[c] = (pkt[c] + 1) % 65536;
        pos[c] = -1;
      end
      p2[c] = p1[c];
      p1[c] = r;
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      logic [8:0] ed;
      rec_t er;
      ed = (hq.size() >= DLYS[c]) ? hq[DLYS[c]-1] : 9'h0;
      er = p2[c];
      total++;
      if ({o_en[c], o_d[c]} !== ed || r_d[c] !== er.d || r_en[c] !== er.en ||
          e_l[c] !== er.err || pc[c] !== 16'(pkt[c])) begin
        bad++;
        $display("FAIL cfg%0d cycle %0d: got dout=%h rep=%h/%b err=%b pkt=%0d want dout=%h rep=%h/%b err=%b pkt=%0d",
          c, cyc_n, {o_en[c], o_d[c]}, r_d[c], r_en[c], e_l[c], pc[c], ed, er.d, er.en, er.err, pkt[c]);
      end
    end
  endtask

  task automatic cyc(input logic e, input logic [7:0] d);
    con_din_en = e; con_din = d;
    @(posedge clk);
    if (rst) model_step(e, d);
    #1;
    cyc_n++;
    check_all();
    if (rst) begin
      if (r_en[0] != 0) log0.push_back({r_en[0], r_d[0]});
      if (r_en[1] != 0) log1.push_back({r_en[1], r_d[1]});
      if (r_en[2] != 0) begin log2.push_back({r_en[2], r_d[2]}); last_rep2 = cyc_n; end
      if (e_l[2]) begin errcnt2++; err_cyc = cyc_n; end
    end
  endtask

  task automatic mid_reset();
    rst = 0;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic lit(input string n, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h want %h", n, got, want); end
  endtask

  function automatic logic [63:0] pk(input logic [11:0] q[$]);
    logic [63:0] v = 0;
    foreach (q[i]) v = {v[51:0], q[i]};
    return v;
  endfunction

  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) cyc(1, b[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'($urandom));
  endtask

  initial begin
    int k;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0);
    lit("reset_pkt", {pc[0], pc[1], pc[2]}, 0);
    rst = 1;
    idle(2);
    send('{8'h05, 8'h11, 8'h22, 8'h33});
    idle(16);
    lit("a_log0", pk(log0), 64'h505511522533);
    lit("a_pkt0", pc[0], 1);
    lit("a_log1", pk(log1), 64'h511522533);
    log0.delete(); log1.delete();
    send('{8'h03, 8'hAA});
    idle(4);
    send('{8'h03});
    idle(4);
    lit("b_log1", pk(log1), 64'h3AA);
    lit("b_pkt1", pc[1], 2);
    log2.delete(); errcnt2 = 0;
    send('{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50});
    idle(6);
    lit("c_log2", pk(log2), 64'h101110120);
    lit("c_err", errcnt2, 1);
    lit("c_err_slot", err_cyc, last_rep2 + 1);
    lit("c_pkt2", pc[2], 4);
    log0.delete(); k = pc[0];
    send('{8'h01, 8'hAB});
    cyc(0, 8'h00);
    send('{8'h08, 8'hCD});
    idle(4);
    lit("d_log0", pk(log0), 64'h1011AB8088CD);
    lit("d_pkt0", pc[0], 64'(k + 2));
    log0.delete(); k = pc[0];
    send('{8'hF0, 8'h01, 8'h02});
    idle(16);
    lit("e_norep", log0.size(), 0);
    lit("e_pkt0", pc[0], 64'(k));
    send('{8'h02, 8'h61});
    mid_reset();
    send('{8'h62, 8'h63});
    rst = 1;
    log0.delete();
    send('{8'h64, 8'h65});
    idle(2);
    send('{8'h02, 8'h77});
    idle(4);
    lit("f_log0", pk(log0), 64'h202277);
    lit("f_pkt0", pc[0], 1);
    for (int p = 0; p < 300; p++) begin
      int len, rp;
      len = ($urandom_range(0, 29) == 0) ? $urandom_range(255, 300) : $urandom_range(1, 8);
      rp = ($urandom_range(0, 39) == 0) ? $urandom_range(0, len - 1) : -1;
      for (int i = 0; i < len; i++) begin
        if (i == rp) begin
          mid_reset();
          for (int j = 0; j < $urandom_range(0, 2); j++) cyc(1, 8'($urandom));
          rst = 1;
        end
        cyc(1, 8'($urandom));
      end
      idle($urandom_range(1, 3));
    end
    idle(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
